// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter:
// FSM state encoding, requester indices, select width and a one-hot helper.
package bus_arbiter4_pkg;

    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] REQ0 = 2'd0;
    localparam logic [SEL_W-1:0] REQ1 = 2'd1;
    localparam logic [SEL_W-1:0] REQ2 = 2'd2;
    localparam logic [SEL_W-1:0] REQ3 = 2'd3;

    function automatic logic [3:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// rr_pick4: combinational round-robin picker over four requests.
// Ports: i_req (request mask), i_ptr (scan start), o_found, o_idx (first set bit from i_ptr).
module rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [3:0]       i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_found,
    output logic [SEL_W-1:0] o_idx
);

    logic [SEL_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest hit to i_ptr wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_ptr;
        w_idx   = i_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + SEL_W'(k);
            if (i_req[w_idx]) begin
                o_found = 1'b1;
                o_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin owner of a shared 4:1 data bus with a bounded hold time.
// Ports: clk, rst (sync, active high), iReq[3:0], iData0..3; oGnt (one-hot), oSel, oBusy, oData.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       iReq,
    input  logic [WIDTH-1:0] iData0,
    input  logic [WIDTH-1:0] iData1,
    input  logic [WIDTH-1:0] iData2,
    input  logic [WIDTH-1:0] iData3,
    output logic [3:0]       oGnt,
    output logic [SEL_W-1:0] oSel,
    output logic             oBusy,
    output logic [WIDTH-1:0] oData
);

    localparam logic [7:0] CNT_MAX = 8'(MAX_HOLD - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [7:0]       r_cnt;

    logic [3:0]       w_req_oth;
    logic             w_found_all;
    logic             w_found_oth;
    logic [SEL_W-1:0] w_idx_all;
    logic [SEL_W-1:0] w_idx_oth;
    logic             w_own_req;
    logic             w_at_limit;
    logic             w_handover;
    logic             w_preempt;
    logic [SEL_W-1:0] w_win;

    // Second picker sees the owner masked out, so preemption never re-picks it.
    assign w_req_oth = iReq & ~onehot4(oSel);

    rr_pick4 u_pick_all (
        .i_req   (iReq),
        .i_ptr   (r_ptr),
        .o_found (w_found_all),
        .o_idx   (w_idx_all)
    );

    rr_pick4 u_pick_oth (
        .i_req   (w_req_oth),
        .i_ptr   (r_ptr),
        .o_found (w_found_oth),
        .o_idx   (w_idx_oth)
    );

    assign w_own_req  = iReq[oSel];
    assign w_at_limit = (r_cnt == CNT_MAX);
    // Release has priority; with the owner gone, the full mask equals the masked one.
    assign w_handover = !w_own_req && w_found_all;
    assign w_preempt  = w_own_req && w_at_limit && w_found_oth;
    assign w_win      = w_own_req ? w_idx_oth : w_idx_all;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= REQ0;
            r_cnt   <= 8'd0;
            oGnt    <= 4'b0000;
            oSel    <= REQ0;
            oBusy   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_found_all) begin
                        r_state <= ST_GRANT;
                        r_ptr   <= w_idx_all + 2'd1;
                        r_cnt   <= 8'd0;
                        oGnt    <= onehot4(w_idx_all);
                        oSel    <= w_idx_all;
                        oBusy   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_handover || w_preempt) begin
                        r_ptr <= w_win + 2'd1;
                        r_cnt <= 8'd0;
                        oGnt  <= onehot4(w_win);
                        oSel  <= w_win;
                    end else if (!w_own_req) begin
                        r_state <= ST_IDLE;
                        oGnt    <= 4'b0000;
                        oBusy   <= 1'b0;
                    end else if (!w_at_limit) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        oData = '0;
        if (oBusy) begin
            case (oSel)
                REQ0:    oData = iData0;
                REQ1:    oData = iData1;
                REQ2:    oData = iData2;
                default: oData = iData3;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Testbench for bus_arbiter4: two instances (MAX_HOLD 4 and 2) share stimulus
// and are compared every cycle against a behavioural round-robin model.
module tb_bus_arbiter4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] d [4];

    logic [3:0]  gA, gB;
    logic [1:0]  sA, sB;
    logic        bA, bB;
    logic [31:0] oA, oB;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int HOLD [2] = '{4, 2};
    int m_busy [2];
    int m_own  [2];
    int m_ptr  [2];
    int m_held [2];

    always #5 clk = ~clk;

    bus_arbiter4 #(.MAX_HOLD(4), .WIDTH(32)) u_a (
        .clk(clk), .rst(rst), .iReq(req),
        .iData0(d[0]), .iData1(d[1]), .iData2(d[2]), .iData3(d[3]),
        .oGnt(gA), .oSel(sA), .oBusy(bA), .oData(oA)
    );

    bus_arbiter4 #(.MAX_HOLD(2), .WIDTH(32)) u_b (
        .clk(clk), .rst(rst), .iReq(req),
        .iData0(d[0]), .iData1(d[1]), .iData2(d[2]), .iData3(d[3]),
        .oGnt(gB), .oSel(sB), .oBusy(bB), .oData(oB)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester in circular order from start, optionally skipping one index.
    function automatic int pick(logic [3:0] r, int start, int skip);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        for (int n = 0; n < 2; n++) begin
            if (rst) begin
                m_busy[n] = 0; m_own[n] = 0; m_ptr[n] = 0; m_held[n] = 0;
            end else if (m_busy[n] == 0) begin
                w = pick(req, m_ptr[n], -1);
                if (w >= 0) begin
                    m_busy[n] = 1; m_own[n] = w; m_ptr[n] = (w + 1) % 4; m_held[n] = 1;
                end
            end else if (!req[m_own[n]]) begin
                w = pick(req, m_ptr[n], -1);
                if (w < 0) m_busy[n] = 0;
                else begin
                    m_own[n] = w; m_ptr[n] = (w + 1) % 4; m_held[n] = 1;
                end
            end else if (m_held[n] >= HOLD[n]) begin
                w = pick(req, m_ptr[n], m_own[n]);
                if (w < 0) m_held[n]++;
                else begin
                    m_own[n] = w; m_ptr[n] = (w + 1) % 4; m_held[n] = 1;
                end
            end else begin
                m_held[n]++;
            end
        end
    end

    function automatic logic [3:0] exp_gnt(int n);
        return (m_busy[n] != 0) ? (4'b0001 << m_own[n]) : 4'b0000;
    endfunction

    function automatic logic [31:0] exp_data(int n);
        return (m_busy[n] != 0) ? d[m_own[n]] : 32'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("A.gnt",  32'(gA), 32'(exp_gnt(0)));
            check("A.sel",  32'(sA), 32'(m_own[0]));
            check("A.busy", 32'(bA), 32'(m_busy[0]));
            check("A.data", oA, exp_data(0));
            check("B.gnt",  32'(gB), 32'(exp_gnt(1)));
            check("B.sel",  32'(sB), 32'(m_own[1]));
            check("B.busy", 32'(bB), 32'(m_busy[1]));
            check("B.data", oB, exp_data(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] flip;
        for (int i = 0; i < 4; i++) d[i] = 32'd0;
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        chk_en = 1'b1;
        check("rst.gnt",  32'(gA), 32'd0);
        check("rst.sel",  32'(sA), 32'd0);
        check("rst.busy", 32'(bA), 32'd0);
        check("rst.data", oA, 32'd0);

        rst = 1'b0;
        req = 4'b0100;
        d[2] = 32'hDEADBEEF;
        step();
        check("single.gnt",  32'(gA), 32'h4);
        check("single.sel",  32'(sA), 32'd2);
        check("single.data", oA, 32'hDEADBEEF);
        req = 4'b0000;
        step();
        check("idle.busy", 32'(bA), 32'd0);
        check("idle.data", oA, 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        check("rr.g0", 32'(gA), 32'h1);
        req = 4'b1110;
        step();
        check("rr.g1", 32'(gA), 32'h2);
        req = 4'b1100;
        step();
        check("rr.g2", 32'(gA), 32'h4);
        req = 4'b1000;
        step();
        check("rr.g3", 32'(gA), 32'h8);
        req = 4'b0000;
        step();
        check("rr.end", 32'(bA), 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0010;
        step();
        check("pre.own1", 32'(gA), 32'h2);
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            step();
            check("pre.own1", 32'(gA), 32'h2);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check("pre.own3", 32'(gA), 32'h8);
        end
        step();
        check("pre.back1", 32'(gA), 32'h2);

        req = 4'b0001;
        for (int k = 0; k < 100; k++) begin
            step();
            check("hold.g0", 32'(gA), 32'h1);
        end

        req = 4'b0010;
        step();
        check("mid.g1", 32'(gA), 32'h2);
        req = 4'b1010;
        rst = 1'b1;
        step();
        check("mid.rgnt",  32'(gA), 32'd0);
        check("mid.rsel",  32'(sA), 32'd0);
        check("mid.rbusy", 32'(bA), 32'd0);
        check("mid.rdata", oA, 32'd0);
        rst = 1'b0;
        step();
        check("mid.regnt", 32'(gA), 32'h2);

        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
        req = 4'b0001;
        step();
        check("col.g0a", 32'(gB), 32'h1);
        req = 4'b0011;
        step();
        check("col.g0b", 32'(gB), 32'h1);
        req = 4'b0010;
        step();
        check("col.g1", 32'(gB), 32'h2);

        for (int c = 0; c < 3000; c++) begin
            flip = 4'b0000;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) flip[b] = 1'b1;
            req = req ^ flip;
            for (int i = 0; i < 4; i++) d[i] = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        rst = 1'b0;
        req = 4'b0000;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Round-robin arbiter that shares one 32-bit datapath bus among four requesters by driving the 2-bit select of the bus's 4:1 data multiplexer. It sits between the requesting units (e.g. ALU result, memory read, PC+4, CP0 read) and the shared writeback/operand bus. It registers a one-hot grant and the matching select, and steers the granted requester's data onto the output. Grants are held for back-to-back cycles, bounded by a hold limit so that no requester starves.

## Interface
- MAX_HOLD, 16: maximum consecutive grant cycles for one owner while another requester waits; legal range 1..255.
- WIDTH, 32: data width.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- iReq  input  4  request per requester; level-sensitive, held until the requester is done.
- iData0..iData3  input  WIDTH each  requester data.
- oGnt  output  4  registered one-hot grant; all zero when idle.
- oSel  output  2  registered mux select; index of the current or last owner.
- oBusy  output  1  registered; high while any grant is active.
- oData  output  WIDTH  combinational; iData[oSel] when oBusy, else 0.

## Operation
- State: IDLE or GRANT. Rotation pointer ptr (2 bits). Hold counter cnt, saturating at MAX_HOLD-1.
- Winner: the first requester with iReq set, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If iReq != 0, the next edge moves to GRANT.
  - On that edge: oSel = winner, oGnt = 1<<winner, oBusy = 1, cnt = 0, ptr = winner+1 (mod 4).
  - If iReq == 0, stay in IDLE; oSel keeps its old value.
- GRANT, evaluated at each edge, first matching rule applies:
  - iReq[oSel] == 0 and other requests are pending: hand over directly to the new winner (scan from ptr, so the old owner is scanned last). cnt = 0, ptr = winner+1. No idle bubble.
  - iReq[oSel] == 0 and no requests remain: return to IDLE. oGnt = 0, oBusy = 0, oSel unchanged.
  - cnt == MAX_HOLD-1 and another requester is waiting: preempt. Grant the winner among the other requesters, cnt = 0, ptr = winner+1. The preempted owner keeps requesting and competes normally.
  - Otherwise: keep the grant and increment cnt (saturating).
- Requests appearing or disappearing for non-owners mid-grant have no effect until the next arbitration edge.
- oData is a pure mux on the registered oSel. It has no added latency and is gated to 0 when idle.

## Timing
- Reset values: state IDLE, oGnt = 0000, oSel = 00, oBusy = 0, oData = 0, ptr = 0, cnt = 0.
- Request-to-grant latency: 1 cycle. iReq rises before edge t, and oGnt is valid after edge t.
- Release: the owner drops iReq before edge t. After edge t the grant is either cleared or moved to the next requester; there is no dead cycle.
- Hold bound: with contention, one owner holds at most MAX_HOLD consecutive cycles. With MAX_HOLD = 1, the grant rotates every cycle.
- Worst-case wait for a continuously requesting unit: 3*MAX_HOLD cycles after its request is sampled.
- rst asserted during GRANT clears all state on that edge. A pending request is re-arbitrated from ptr = 0 on the first edge after rst deasserts.
- Simultaneous release and preempt on the same edge: the release rule wins. The result is the same grant, with the old owner scanned last.

## Structure
- Shared package: the state encoding (IDLE = 0, GRANT = 1), the requester index constants (REQ0..REQ3), and the select width of 2.
- Sub-module rr_pick4: a combinational round-robin picker. Inputs are a 4-bit request mask and a 2-bit ptr. Outputs are a found flag and a 2-bit index.
  - It is instantiated twice: once on the full iReq, and once on iReq with the owner's bit masked, for preemption.
- The counter, the FSM and the output mux live in bus_arbiter4.

## Test plan
- Reset and single request:
  - rst high for 2 cycles, then iReq = 0100 -> oGnt = 0100 and oSel = 2 one cycle later.
  - iData2 = 0xDEADBEEF -> oData = 0xDEADBEEF.
  - iReq = 0 -> oBusy = 0 and oData = 0 one cycle later.
- Simultaneous requests from reset:
  - iReq = 1111, each requester drops one cycle after receiving its grant -> grant order 0, 1, 2, 3 with no idle cycles.
- Preemption with MAX_HOLD = 4:
  - iReq[1] held high, iReq[3] raised 1 cycle later -> requester 1 holds exactly 4 cycles, then oGnt = 1000.
  - Requester 3 also holds 4 cycles, then the grant returns to 1.
- No-contention hold:
  - iReq = 0001 held for 100 cycles with MAX_HOLD = 4 -> oGnt stays 0001 throughout and cnt saturates.
- Mid-grant reset:
  - rst pulsed while oGnt = 0010 and iReq = 1010 -> outputs at reset values on the next cycle.
  - Then oGnt = 0010 (scan restarts at ptr = 0).
- Release/preempt collision, MAX_HOLD = 2:
  - The owner drops on the same edge where cnt hits 1 with another requester waiting -> the waiting requester is granted on that edge.
